// File: rtl/div_ctrl_pkg.sv
// Shared types and helpers for the ratio-update clock divider.
package div_ctrl_pkg;

  // Controller states: accepting, waiting for a period boundary, settling
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // A ratio is usable when it lies in 2..max
  function automatic logic legal_ratio(input int unsigned ratio, input int unsigned max);
    return (ratio >= 2) && (ratio <= max);
  endfunction

endpackage

// File: rtl/div_core.sv
// Divider core: period counter, registered divided clock and wrap flag.
// A load replaces the ratio and restarts the period; it is only issued
// on a wrap edge, so the old period always completes first.
module div_core #(
  parameter int NBW       = 5,
  parameter int NDIV_INIT = 2
) (
  input  logic           cki,
  input  logic           rst,
  input  logic           load,
  input  logic [NBW-1:0] load_ratio,
  output logic           cko,
  output logic [NBW-1:0] ratio,
  output logic           wrap
);

  logic [NBW-1:0] cntr_reg, cntr_next;
  logic [NBW-1:0] ratio_reg, ratio_next;
  logic           cko_reg, cko_next;

  // Next count, next ratio and next cko level (cko uses the ratio that will apply)
  always_comb begin
    wrap       = (cntr_reg == (ratio_reg - NBW'(1)));
    ratio_next = ratio_reg;
    cntr_next  = wrap ? '0 : (cntr_reg + NBW'(1));
    if (load) begin
      ratio_next = load_ratio;
      cntr_next  = '0;
    end
    cko_next = (cntr_next >= (ratio_next >> 1));
  end

  // Counter, ratio and divided-clock flops
  always_ff @(posedge cki or posedge rst) begin
    if (rst) begin
      cntr_reg  <= '0;
      ratio_reg <= NBW'(NDIV_INIT);
      cko_reg   <= 1'b0;
    end else begin
      cntr_reg  <= cntr_next;
      ratio_reg <= ratio_next;
      cko_reg   <= cko_next;
    end
  end

  assign cko   = cko_reg;
  assign ratio = ratio_reg;

endmodule

// File: rtl/div_ratio_ctrl.sv
// Runtime-programmable clock divider with ratio-update controller.
// New ratios arrive over valid/ready, are applied on a period boundary,
// then NSETTLE periods are counted before locked is reported.
// Optional macro DIV_ERR_STICKY_EN: err becomes a sticky bit cleared by err_clr.
module div_ratio_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int NDIV_MAX  = 16,
  parameter int NDIV_INIT = 2,
  parameter int NSETTLE   = 4,
  localparam int NBW      = $clog2(NDIV_MAX + 1)
) (
  input  logic           cki,
  input  logic           rst,
  input  logic           req_valid,
  input  logic [NBW-1:0] req_ratio,
`ifdef DIV_ERR_STICKY_EN
  input  logic           err_clr,
`endif
  output logic           req_ready,
  output logic           cko,
  output logic [NBW-1:0] cur_ratio,
  output logic           locked,
  output logic           upd_done,
  output logic           err
);

  localparam int SBW = $clog2(NSETTLE + 1);

  state_t         state_reg, state_next;
  logic [SBW-1:0] settle_reg, settle_next;
  logic [NBW-1:0] pend_reg, pend_next;
  logic           locked_reg, locked_next;
  logic           upd_reg, upd_next;
  logic           err_reg, err_next;
  logic           init_reg, init_next;
  logic           err_set;
  logic           wrap;
  logic           load;

  // A pending ratio is loaded exactly when the old period completes
  assign load = (state_reg == PEND) && wrap;

  div_core #(
    .NBW       (NBW),
    .NDIV_INIT (NDIV_INIT)
  ) u_core (
    .cki        (cki),
    .rst        (rst),
    .load       (load),
    .load_ratio (pend_reg),
    .cko        (cko),
    .ratio      (cur_ratio),
    .wrap       (wrap)
  );

  // Next-state, handshake and settle-count decisions
  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    pend_next   = pend_reg;
    locked_next = locked_reg;
    init_next   = init_reg;
    upd_next    = 1'b0;
    err_set     = 1'b0;
    case (state_reg)
      IDLE: begin
        locked_next = 1'b1;
        if (req_valid) begin
          if (legal_ratio(32'(req_ratio), NDIV_MAX)) begin
            pend_next   = req_ratio;
            state_next  = PEND;
            locked_next = 1'b0;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      PEND: begin
        if (wrap) begin
          settle_next = '0;
          state_next  = SETTLE;
        end
      end
      SETTLE: begin
        if (wrap) begin
          if (settle_reg == SBW'(NSETTLE - 1)) begin
            settle_next = '0;
            state_next  = IDLE;
            locked_next = 1'b1;
            upd_next    = ~init_reg;  // no completion pulse for the post-reset settle
            init_next   = 1'b0;
          end else begin
            settle_next = settle_reg + SBW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef DIV_ERR_STICKY_EN
    err_next = err_set | (err_reg & ~err_clr);  // set wins over clear
`else
    err_next = err_set;
`endif
  end

  // Controller state and status flops
  always_ff @(posedge cki or posedge rst) begin
    if (rst) begin
      state_reg  <= SETTLE;
      settle_reg <= '0;
      pend_reg   <= NBW'(NDIV_INIT);
      locked_reg <= 1'b0;
      upd_reg    <= 1'b0;
      err_reg    <= 1'b0;
      init_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
      pend_reg   <= pend_next;
      locked_reg <= locked_next;
      upd_reg    <= upd_next;
      err_reg    <= err_next;
      init_reg   <= init_next;
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign locked    = locked_reg;
  assign upd_done  = upd_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Self-checking bench for div_ratio_ctrl against a period/phase reference model.
module tb_div_ratio_ctrl;

  localparam int NDIV_MAX  = 16;
  localparam int NDIV_INIT = 2;
  localparam int NSETTLE   = 4;
  localparam int NBW       = $clog2(NDIV_MAX + 1);

  localparam int M_LOCK = 0;
  localparam int M_WAIT = 1;
  localparam int M_SET  = 2;

  logic           cki = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic [NBW-1:0] req_ratio = '0;
`ifdef DIV_ERR_STICKY_EN
  logic           err_clr = 1'b0;
`endif
  logic           req_ready;
  logic           cko;
  logic [NBW-1:0] cur_ratio;
  logic           locked;
  logic           upd_done;
  logic           err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: ratio, position within the period, and mode
  int m_ratio, m_phase, m_mode, m_left, m_pend;
  bit m_init, m_err, m_upd, m_acc;

  div_ratio_ctrl #(
    .NDIV_MAX  (NDIV_MAX),
    .NDIV_INIT (NDIV_INIT),
    .NSETTLE   (NSETTLE)
  ) dut (
    .cki       (cki),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ratio (req_ratio),
`ifdef DIV_ERR_STICKY_EN
    .err_clr   (err_clr),
`endif
    .req_ready (req_ready),
    .cko       (cko),
    .cur_ratio (cur_ratio),
    .locked    (locked),
    .upd_done  (upd_done),
    .err       (err)
  );

  always #5 cki = ~cki;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ratio = NDIV_INIT;
    m_phase = 0;
    m_mode  = M_SET;
    m_left  = NSETTLE * NDIV_INIT;
    m_pend  = NDIV_INIT;
    m_init  = 1;
    m_err   = 0;
    m_upd   = 0;
    m_acc   = 0;
  endtask

  // one clock edge of the model, using the inputs that were stable at that edge
  task automatic model_edge();
    bit end_of_period;
    bit set;
    int nxt;
    if (rst) begin
      model_reset();
      return;
    end
    end_of_period = (m_phase == m_ratio - 1);
    nxt   = end_of_period ? 0 : m_phase + 1;
    set   = 0;
    m_upd = 0;
    m_acc = 0;
    if (m_mode == M_LOCK) begin
      m_phase = nxt;
      if (req_valid) begin
        m_acc = 1;
        if (req_ratio >= 2 && req_ratio <= NDIV_MAX) begin
          m_pend = req_ratio;
          m_mode = M_WAIT;
        end else begin
          set = 1;
        end
      end
    end else if (m_mode == M_WAIT) begin
      if (end_of_period) begin
        m_ratio = m_pend;
        m_phase = 0;
        m_mode  = M_SET;
        m_left  = NSETTLE * m_pend;
      end else begin
        m_phase = nxt;
      end
    end else begin
      m_phase = nxt;
      m_left--;
      if (m_left == 0) begin
        m_mode = M_LOCK;
        m_upd  = !m_init;
        m_init = 0;
      end
    end
`ifdef DIV_ERR_STICKY_EN
    m_err = set | (m_err & !err_clr);
`else
    m_err = set;
`endif
  endtask

  task automatic compare_all();
    check("cko", cko, (m_phase >= m_ratio / 2) ? 1 : 0);
    check("cur_ratio", cur_ratio, m_ratio);
    check("locked", locked, (m_mode == M_LOCK) ? 1 : 0);
    check("req_ready", req_ready, (m_mode == M_LOCK) ? 1 : 0);
    check("upd_done", upd_done, m_upd);
    check("err", err, m_err);
  endtask

  task automatic step();
    @(posedge cki);
    #1;
    cyc++;
    model_edge();
    compare_all();
  endtask

  // asynchronous reset asserted between edges, held over one edge
  task automatic do_async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_cko", cko, 0);
    check("rst_locked", locked, 0);
    check("rst_ratio", cur_ratio, NDIV_INIT);
    step();
    rst = 1'b0;
  endtask

  // count edges until locked; expect a full settle at the init ratio
  task automatic count_lock(input string tag);
    int n = 0;
    while (!locked && n < 200) begin
      step();
      n++;
    end
    check(tag, n, NSETTLE * NDIV_INIT);
  endtask

  task automatic do_req(input int r);
    int n = 0;
    req_valid = 1'b1;
    req_ratio = NBW'(r);
    m_acc = 0;
    while (!m_acc && n < 300) begin
      step();
      n++;
    end
    if (!m_acc) check("req_accept_timeout", 0, 1);
    req_valid = 1'b0;
    $display("req ratio=%0d taken cycle=%0d err=%0d cur_ratio=%0d", r, cyc, err, cur_ratio);
  endtask

  task automatic wait_lock();
    int n = 0;
    while (m_mode != M_LOCK && n < 300) begin
      step();
      n++;
    end
    if (m_mode != M_LOCK) check("lock_timeout", 0, 1);
  endtask

  initial begin
    model_reset();
    #1;
    step();
    step();
    rst = 1'b0;
    count_lock("post_reset_lock_edges");
    repeat (3) step();

    do_req(5);
    wait_lock();
    check("ratio5", cur_ratio, 5);
    repeat (7) step();

    do_req(1);
    repeat (3) step();
    do_req(17);
    repeat (6) step();

    do_req(4);
    do_req(3);   // held valid through the update to 4
    wait_lock();
    check("ratio3", cur_ratio, 3);
    repeat (6) step();

    do_req(8);
    begin
      int n = 0;
      while (m_mode != M_SET && n < 50) begin
        step();
        n++;
      end
    end
    repeat (12) step();
    do_async_reset();
    count_lock("relock_edges");

`ifdef DIV_ERR_STICKY_EN
    do_req(0);
    check("sticky_set", err, 1);
    step();
    err_clr = 1'b1;
    do_req(17);
    check("sticky_set_wins", err, 1);
    step();
    err_clr = 1'b0;
    check("sticky_cleared", err, 0);
    step();
`endif

    // randomized traffic, occasional reset
    for (int i = 0; i < 2500; i++) begin
      req_valid = ($urandom_range(0, 3) == 0);
      req_ratio = ($urandom_range(0, 4) == 0) ? NBW'($urandom_range(0, 31))
                                              : NBW'($urandom_range(2, NDIV_MAX));
`ifdef DIV_ERR_STICKY_EN
      err_clr = ($urandom_range(0, 5) == 0);
`endif
      if ($urandom_range(0, 399) == 0) begin
        req_valid = 1'b0;
        do_async_reset();
      end else begin
        step();
      end
    end
    req_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_ratio_ctrl.md
Name: div_ratio_ctrl

Overview:
- Runtime-programmable clock divider with a ratio-update controller.
- Accepts new divide ratios over a valid/ready handshake and applies each one only at a divided-clock period boundary, so cko never glitches.
- Counts a settling interval after every switch, then reports lock.
- Sits in the clocking block between the config/CSR logic and the divided-clock consumers (deserializer, framer).

Parameters:
- NDIV_MAX, 16: largest legal ratio. Legal range is 2..NDIV_MAX.
- NDIV_INIT, 2: ratio loaded at reset. Must lie in 2..NDIV_MAX.
- NSETTLE, 4: number of complete cko periods counted after a switch before locked asserts. Must be ≥1.
- Derived localparam NBW = $clog2(NDIV_MAX+1): ratio field width.

Ports:
- cki  input  1  input clock; all flops are posedge cki.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  new-ratio request.
- req_ratio  input  NBW  requested divide ratio.
- req_ready  output  1  controller can accept a request.
- cko  output  1  divided clock, driven directly from a flop.
- cur_ratio  output  NBW  ratio currently applied.
- locked  output  1  divider is stable at cur_ratio.
- upd_done  output  1  one-cycle pulse when an update completes.
- err  output  1  one-cycle pulse when an illegal ratio is accepted.

Behaviour:
- Counter
  - cntr runs 0..cur_ratio-1.
  - A wrap is any edge where cntr==cur_ratio-1; cntr then goes to 0.
  - cko is registered: each edge, cko <= (cntr_next >= cur_ratio>>1).
  - Resulting patterns: ratio 4 gives 0,0,1,1; ratio 3 gives 0,1,1; ratio 5 gives 0,0,1,1,1.
- Reset (asynchronous)
  - cntr=0, cko=0, cur_ratio=NDIV_INIT.
  - state=SETTLE, settle_cnt=0.
  - locked=0, upd_done=0, err=0.
  - Any pending request is dropped.
- FSM states: IDLE, PEND, SETTLE. req_ready = (state==IDLE); it is decoded from the state flop only, with no combinational path from req_valid.
- IDLE
  - locked=1.
  - On req_valid&&req_ready with req_ratio in 2..NDIV_MAX: latch pend_ratio, go to PEND, locked<=0 on the same edge.
  - An equal-to-current ratio is legal and goes through the full sequence.
  - With an illegal ratio (0, 1, or >NDIV_MAX): err pulses 1 cycle, state stays IDLE, locked stays 1, cur_ratio is unchanged.
- PEND
  - The counter keeps running at the old ratio.
  - On the wrap edge: cur_ratio<=pend_ratio, cntr<=0, settle_cnt<=0, go to SETTLE.
  - cko on that edge is computed using the new ratio. This is glitch-free because cntr_next=0 gives cko=0, and the old period has just completed.
- SETTLE
  - settle_cnt increments on each wrap at cur_ratio.
  - On the wrap that makes settle_cnt==NSETTLE: go to IDLE, locked<=1, and pulse upd_done 1 cycle.
  - This pulse is suppressed for the post-reset settle.
- Requests presented outside IDLE are not accepted. req_valid may stay high and is taken on the first IDLE cycle.
- Latency from request acceptance to locked:
  - (cycles to the old-ratio wrap) + NSETTLE*new_ratio edges.
  - Post-reset lock takes NSETTLE*NDIV_INIT edges.
- Reset asserted mid-PEND or mid-SETTLE returns immediately to the reset values; cur_ratio reverts to NDIV_INIT.

Optional Feature:
- Macro: DIV_ERR_STICKY_EN.
- Defined:
  - err becomes a sticky status bit, set by an illegal-ratio acceptance and cleared only by rst or by an added input port err_clr (1 bit, synchronous).
  - If set and clear occur in the same cycle, set wins.
- Undefined: err is the 1-cycle pulse described above and the err_clr port is absent.

Decomposition:
- Package div_ctrl_pkg holds:
  - the state enum typedef {IDLE, PEND, SETTLE};
  - the function legal_ratio(ratio, max).
- One natural sub-module, div_core: cntr, registered cko and the wrap flag, with a load port for the new ratio. div_ratio_ctrl contains the FSM, the handshake and the settle counter.

Test Plan:
- Reset release with NDIV_INIT=2, NSETTLE=4 -> cko toggles every cki edge; locked rises on the 8th posedge; no upd_done pulse; req_ready is 1 from that cycle.
- Accept req_ratio=5 while at ratio 2 -> switch on the next wrap; then cko pattern 0,0,1,1,1 repeating; locked and upd_done after 20 more edges; cur_ratio=5.
- req_ratio=1, then req_ratio=17 (NDIV_MAX=16) -> err pulses once each; locked stays 1; cur_ratio and cko period unchanged.
- Hold req_valid=1 with ratio 3 during an active update to 4 -> the second request is accepted on the first IDLE cycle after upd_done; final cur_ratio=3; cko pattern 0,1,1.
- Assert rst midway through SETTLE after a request for 8 -> immediate cko=0 and locked=0; cur_ratio=2; relock after 8 edges.
- DIV_ERR_STICKY_EN defined: illegal request, then err_clr asserted together with a second illegal request -> err stays 1; a lone err_clr then clears it to 0.
